// File: rtl/darksim_pkg.sv
// Shared types and helpers for the darksim memory responder.
package darksim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] DLEN_B = 3'b001;
    localparam logic [2:0] DLEN_H = 3'b010;
    localparam logic [2:0] DLEN_W = 3'b100;

    typedef struct packed {
        logic [3:0] mask;
        logic       misaligned;
    } lane_t;

    // Byte-enable mask for an access. An unknown DLEN code is reported as
    // misaligned so the caller needs only one "bad shape" flag.
    function automatic lane_t lane_mask(input logic [2:0] dlen, input logic [1:0] a);
        lane_t r;
        r.mask       = 4'b0000;
        r.misaligned = 1'b0;
        case (dlen)
            DLEN_B: r.mask = 4'b0001 << a;
            DLEN_H: begin
                r.mask       = 4'b0011 << {a[1], 1'b0};
                r.misaligned = a[0];
            end
            DLEN_W: begin
                r.mask       = 4'b1111;
                r.misaligned = (a != 2'b00);
            end
            default: r.misaligned = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/darksim_ram.sv
// Word-wide memory: registered instruction read port plus a data port with
// registered read and byte-enable write. Reads return the pre-write contents.
module darksim_ram #(
    parameter int unsigned DEPTH_W   = 4096,
    parameter int unsigned AW        = 12,
    parameter string       INIT_FILE = ""
) (
    input  logic          clk_i,
    input  logic [AW-1:0] i_addr_i,
    output logic [31:0]   i_rdata_o,
    input  logic [AW-1:0] d_addr_i,
    input  logic [3:0]    d_be_i,
    input  logic [31:0]   d_wdata_i,
    output logic [31:0]   d_rdata_o
);

    logic [31:0] mem_q [DEPTH_W];
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;

    // Byte-lane writes and both registered reads share one clocked block.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (d_be_i[b]) begin
                mem_q[d_addr_i][8*b +: 8] <= d_wdata_i[8*b +: 8];
            end
        end
        i_rdata_q <= mem_q[i_addr_i];
        d_rdata_q <= mem_q[d_addr_i];
    end

    assign i_rdata_o = i_rdata_q;
    assign d_rdata_o = d_rdata_q;

endmodule

// File: rtl/darksim_mem.sv
// Simulation memory / bus responder for the darkriscv core: 1-cycle
// instruction port, wait-stated data port, exit mailbox and sticky error.
module darksim_mem
    import darksim_pkg::*;
#(
    parameter int unsigned DEPTH_W   = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned DWAIT     = 1,
    parameter logic [31:0] EXIT_ADDR = 32'h8000_0000,
    parameter string       INIT_FILE = ""
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic [31:0] IADDR,
    output logic [31:0] IDATA,
    input  logic [31:0] DADDR,
    input  logic        DAS,
    input  logic        DRD,
    input  logic        DWR,
    input  logic [2:0]  DLEN,
    input  logic [31:0] DATAO,
    output logic [31:0] DATAI,
    output logic        HLT,
    output logic        SIM_DONE,
    output logic [31:0] SIM_CODE,
    output logic        ERR
);

    localparam int unsigned AW        = $clog2(DEPTH_W);
    localparam logic [32:0] SPAN      = 33'(DEPTH_W) << 2;
    localparam logic [3:0]  WAIT_LOAD = (DWAIT == 0) ? 4'd0 : 4'(DWAIT - 1);

    if (DWAIT > 15) begin : g_dwait_chk
        $error("darksim_mem: DWAIT must be in 0..15");
    end
    if ((1 << AW) != DEPTH_W) begin : g_depth_chk
        $error("darksim_mem: DEPTH_W must be a power of two");
    end

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] idx_q;
    logic [3:0]    mask_q;
    logic [31:0]   wdata_q;
    logic          rd_q, wr_q, bad_q, exit_q;
    logic [31:0]   datai_q, code_q;
    logic          done_q, err_q, ifetch_ok_q;

    logic [31:0]   d_off, i_off;
    logic          d_in_range, i_in_range, d_exit, accept_d, bad_d;
    lane_t         lane_d;
    logic [AW-1:0] ram_d_addr;
    logic [3:0]    ram_be;
    logic [31:0]   ram_idata, ram_ddata;
    logic          unused_ok;

    assign d_off      = DADDR - BASE_ADDR;
    assign i_off      = IADDR - BASE_ADDR;
    assign d_in_range = ({1'b0, d_off} < SPAN);
    assign i_in_range = ({1'b0, i_off} < SPAN);
    assign d_exit     = (DADDR[31:2] == EXIT_ADDR[31:2]);
    assign lane_d     = lane_mask(DLEN, DADDR[1:0]);
    assign accept_d   = (state_q == IDLE) && DAS && (DRD || DWR);
    // Any of these turns the access into a no-op that still runs the FSM.
    assign bad_d      = lane_d.misaligned | (DRD & DWR) | (!d_in_range & !d_exit);

    // While idle the RAM reads the live address so the word is ready by RESP
    // even with no wait states; afterwards it tracks the latched request.
    assign ram_d_addr = (state_q == IDLE) ? d_off[AW+1:2] : idx_q;
    assign ram_be     = (RES_N && state_q == RESP && wr_q && !bad_q && !exit_q)
                        ? mask_q : 4'b0000;

    assign HLT      = accept_d || (state_q == WAIT);
    assign IDATA    = ifetch_ok_q ? ram_idata : 32'h0;
    assign DATAI    = datai_q;
    assign SIM_DONE = done_q;
    assign SIM_CODE = code_q;
    assign ERR      = err_q;

    assign unused_ok = ^{i_off[31:AW+2], i_off[1:0], d_off[31:AW+2], d_off[1:0]};

    darksim_ram #(
        .DEPTH_W   (DEPTH_W),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk_i     (CLK),
        .i_addr_i  (i_off[AW+1:2]),
        .i_rdata_o (ram_idata),
        .d_addr_i  (ram_d_addr),
        .d_be_i    (ram_be),
        .d_wdata_i (wdata_q),
        .d_rdata_o (ram_ddata)
    );

    // Data-port FSM, request latch, wait counter, mailbox and error flag.
    always_ff @(posedge CLK) begin
        if (!RES_N) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            mask_q      <= 4'b0000;
            wdata_q     <= 32'h0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            bad_q       <= 1'b0;
            exit_q      <= 1'b0;
            datai_q     <= 32'h0;
            code_q      <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ifetch_ok_q <= 1'b0;
        end else begin
            ifetch_ok_q <= i_in_range;
            if (!i_in_range) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        idx_q   <= d_off[AW+1:2];
                        mask_q  <= lane_d.mask;
                        wdata_q <= DATAO;
                        rd_q    <= DRD;
                        wr_q    <= DWR;
                        bad_q   <= bad_d;
                        exit_q  <= d_exit;
                        if (DWAIT == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    if (bad_q) begin
                        err_q   <= 1'b1;
                        datai_q <= 32'h0;
                    end else if (rd_q) begin
                        datai_q <= exit_q ? 32'h0 : ram_ddata;
                    end
                    // First exit write wins; later ones are ignored.
                    if (wr_q && exit_q && !bad_q && !done_q) begin
                        done_q <= 1'b1;
                        code_q <= wdata_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_darksim_mem.sv
// Directed bench for darksim_mem: vector table of data accesses plus
// hand-written fetch, read-before-write and reset-mid-access sequences.
module tb_darksim_mem;

    localparam int DW = 2;
    localparam logic [2:0] LB = 3'b001;
    localparam logic [2:0] LH = 3'b010;
    localparam logic [2:0] LW = 3'b100;

    logic        clk;
    logic        res_n;
    logic [31:0] iaddr, idata, daddr, datao, datai, sim_code;
    logic        das, drd, dwr, hlt, sim_done, err;
    logic [2:0]  dlen;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_d;
        logic        exp_err;
    } vec_t;

    vec_t vecs [24];

    darksim_mem #(
        .DEPTH_W   (4096),
        .BASE_ADDR (32'h0),
        .DWAIT     (DW),
        .EXIT_ADDR (32'h8000_0000),
        .INIT_FILE ("")
    ) dut (
        .CLK      (clk),
        .RES_N    (res_n),
        .IADDR    (iaddr),
        .IDATA    (idata),
        .DADDR    (daddr),
        .DAS      (das),
        .DRD      (drd),
        .DWR      (dwr),
        .DLEN     (dlen),
        .DATAO    (datao),
        .DATAI    (datai),
        .HLT      (hlt),
        .SIM_DONE (sim_done),
        .SIM_CODE (sim_code),
        .ERR      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one access at a negedge, count HLT cycles, release in RESP and
    // return at the negedge of the cycle after RESP (DATAI valid there).
    task automatic access(input logic rd, input logic wr, input logic [2:0] len,
                          input logic [31:0] a, input logic [31:0] d, output int n);
        das = 1'b1; drd = rd; dwr = wr; dlen = len; daddr = a; datao = d;
        n = 0;
        #1;
        while (hlt && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        das = 1'b0; drd = 1'b0; dwr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;

        vecs[0]  = '{1'b0, 1'b1, LW,     32'h20,        32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 1'b0, LW,     32'h20,        32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, LW,     32'h10,        32'h0000_0013, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 1'b1, LW,     32'h20,        32'h1122_3344, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 1'b1, LB,     32'h22,        32'h00AA_0000, 32'h0,         1'b0};
        vecs[5]  = '{1'b1, 1'b0, LW,     32'h20,        32'h0,         32'h11AA_3344, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, LH,     32'h20,        32'h0000_BBCC, 32'h0,         1'b0};
        vecs[7]  = '{1'b1, 1'b0, LW,     32'h20,        32'h0,         32'h11AA_BBCC, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, LW,     32'h2C,        32'h0102_0304, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 1'b1, LH,     32'h2E,        32'hABCD_0000, 32'h0,         1'b0};
        vecs[10] = '{1'b1, 1'b0, LW,     32'h2C,        32'h0,         32'hABCD_0304, 1'b0};
        vecs[11] = '{1'b1, 1'b0, LB,     32'h21,        32'h0,         32'h11AA_BBCC, 1'b0};
        vecs[12] = '{1'b1, 1'b0, LW,     32'h8000_0000, 32'h0,         32'h0,         1'b0};
        vecs[13] = '{1'b0, 1'b1, LW,     32'h8000_0000, 32'h1,         32'h0,         1'b0};
        vecs[14] = '{1'b0, 1'b1, LW,     32'h8000_0000, 32'h2,         32'h0,         1'b0};
        vecs[15] = '{1'b0, 1'b1, LH,     32'h21,        32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[16] = '{1'b1, 1'b0, LW,     32'h20,        32'h0,         32'h11AA_BBCC, 1'b1};
        vecs[17] = '{1'b1, 1'b0, LW,     32'h4000,      32'h0,         32'h0,         1'b1};
        vecs[18] = '{1'b1, 1'b0, LW,     32'h20,        32'h0,         32'h11AA_BBCC, 1'b1};
        vecs[19] = '{1'b1, 1'b0, 3'b011, 32'h20,        32'h0,         32'h0,         1'b1};
        vecs[20] = '{1'b1, 1'b0, LW,     32'h22,        32'h0,         32'h0,         1'b1};
        vecs[21] = '{1'b1, 1'b0, LW,     32'h2C,        32'h0,         32'hABCD_0304, 1'b1};
        vecs[22] = '{1'b1, 1'b1, LW,     32'h2C,        32'h5A5A_5A5A, 32'h0,         1'b1};
        vecs[23] = '{1'b1, 1'b0, LW,     32'h2C,        32'h0,         32'hABCD_0304, 1'b1};

        res_n = 1'b0; iaddr = 32'h0; das = 1'b0; drd = 1'b0; dwr = 1'b0;
        dlen = LW; daddr = 32'h0; datao = 32'h0;

        // Power-on reset state
        repeat (3) @(negedge clk);
        check("rst_idata", idata, 32'h0);
        check("rst_datai", datai, 32'h0);
        check("rst_hlt", 32'(hlt), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_done", 32'(sim_done), 32'h0);
        check("rst_code", sim_code, 32'h0);
        res_n = 1'b1;
        @(negedge clk);

        // Table of data-port accesses
        for (int i = 0; i < 24; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].len, vecs[i].addr, vecs[i].wdata, n);
            $display("[TB] vec %0d rd=%0b wr=%0b len=%03b addr=%h wdata=%h -> datai=%h err=%0b hlt_cycles=%0d",
                     i, vecs[i].rd, vecs[i].wr, vecs[i].len, vecs[i].addr, vecs[i].wdata, datai, err, n);
            check($sformatf("vec%0d_hlt_cycles", i), 32'(n), 32'(DW + 1));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            if (vecs[i].rd) begin
                check($sformatf("vec%0d_datai", i), datai, vecs[i].exp_d);
            end
        end
        check("exit_done", 32'(sim_done), 32'h1);
        check("exit_code", sim_code, 32'h1);

        // Instruction fetch: one-cycle latency, no stall
        iaddr = 32'h10;
        @(negedge clk);
        $display("[TB] fetch iaddr=%h -> idata=%h hlt=%0b", iaddr, idata, hlt);
        check("fetch_idata", idata, 32'h0000_0013);
        check("fetch_hlt", 32'(hlt), 32'h0);

        // Same-word fetch and data write: fetch sees the old word first
        iaddr = 32'h2C;
        @(negedge clk);
        check("rbw_before", idata, 32'hABCD_0304);
        access(1'b0, 1'b1, LW, 32'h2C, 32'h7777_7777, n);
        $display("[TB] rbw write 0x2C -> idata=%h", idata);
        check("rbw_old", idata, 32'hABCD_0304);
        @(negedge clk);
        check("rbw_new", idata, 32'h7777_7777);

        // Reset in the middle of a pending write
        das = 1'b1; dwr = 1'b1; drd = 1'b0; dlen = LW; daddr = 32'h2C; datao = 32'h1234_5678;
        #1;
        check("t1_hlt_req", 32'(hlt), 32'h1);
        @(negedge clk);
        check("t1_hlt_wait", 32'(hlt), 32'h1);
        res_n = 1'b0; das = 1'b0; dwr = 1'b0;
        @(negedge clk);
        check("t1_hlt_drop", 32'(hlt), 32'h0);
        @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
        $display("[TB] reset mid-write -> hlt=%0b datai=%h err=%0b done=%0b", hlt, datai, err, sim_done);
        check("t1_hlt", 32'(hlt), 32'h0);
        check("t1_datai", datai, 32'h0);
        check("t1_err", 32'(err), 32'h0);
        check("t1_done", 32'(sim_done), 32'h0);
        check("t1_code", sim_code, 32'h0);
        access(1'b1, 1'b0, LW, 32'h2C, 32'h0, n);
        $display("[TB] read 0x2C after reset -> datai=%h", datai);
        check("t1_no_write", datai, 32'h7777_7777);
        check("t1_read_hlt", 32'(n), 32'(DW + 1));
        check("t1_err_after", 32'(err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
